// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode-stage pipeline controller.
// Contents:
//   sb_entry_t - one scoreboard slot {valid, rd[3:0], load}
//   REG_PC     - architectural PC register number (reads never hazard)
//   NOP_INSN   - NOP encoding shared with the decode pipeline register
//   src_hit()  - helper: a used source register matches a valid slot
package pipeline_pkg;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       load;
  } sb_entry_t;

  localparam logic [3:0]  REG_PC   = 4'd15;
  localparam logic [31:0] NOP_INSN = 32'hE320F000;

  function automatic logic src_hit(input logic [3:0] src,
                                   input logic       used,
                                   input sb_entry_t  e);
    return used && e.valid && (src == e.rd) && (src != REG_PC);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination-register scoreboard.
// A DEPTH-entry shift register (entry 0 = execute, entry DEPTH-1 = last stage
// before register write) plus source-match logic per entry.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   i_rn/i_rm/i_rs     - decode source registers
//   i_use_rn/rm/rs     - source-register read enables
//   i_new              - entry loaded into slot 0 at the next edge
//   o_match[DEPTH-1:0] - per-entry hazard match
// Macro PIPE_HAZARD_FWD_EN: with forwarding, only a load in entry 0 can
// produce a match (one-cycle load-use stall).
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i_rn,
  input  logic [3:0]       i_rm,
  input  logic [3:0]       i_rs,
  input  logic             i_use_rn,
  input  logic             i_use_rm,
  input  logic             i_use_rs,
  input  sb_entry_t        i_new,
  output logic [DEPTH-1:0] o_match
);

  sb_entry_t r_sb [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_sb[k] <= '0;
    end else begin
      r_sb[0] <= i_new;
      for (int unsigned k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
    end
  end

  always_comb begin
    o_match = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
`ifdef PIPE_HAZARD_FWD_EN
      if (k == 0 && r_sb[k].load)
`endif
        o_match[k] = src_hit(i_rn, i_use_rn, r_sb[k]) |
                     src_hit(i_rm, i_use_rm, r_sb[k]) |
                     src_hit(i_rs, i_use_rs, r_sb[k]);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the decode-stage pipeline register.
// Stalls decode on read-after-write hazards, owns the branch epoch bit used
// to squash wrong-path instructions, and keeps stall statistics.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   branch_value               - epoch tag of the instruction in decode
//   dec_rn/rm/rs/rd, use_*     - decode register fields and read enables
//   dec_wr, dec_load           - decode writes Rd / Rd comes from memory
//   br_taken                   - execute resolved a taken branch
//   sel_stall                  - hold decode register and fetch
//   branch_ref, branch_in      - current epoch (compare / fetch tag)
//   stall_run, stall_total     - saturating stall counters
// Macro PIPE_HAZARD_FWD_EN: ALU results forwarded; only load-use stalls.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_value,
  input  logic [3:0]       dec_rn,
  input  logic [3:0]       dec_rm,
  input  logic [3:0]       dec_rs,
  input  logic [3:0]       dec_rd,
  input  logic             use_rn,
  input  logic             use_rm,
  input  logic             use_rs,
  input  logic             dec_wr,
  input  logic             dec_load,
  input  logic             br_taken,
  output logic             sel_stall,
  output logic             branch_ref,
  output logic             branch_in,
  output logic [CNT_W-1:0] stall_run,
  output logic [CNT_W-1:0] stall_total
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_epoch;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_total;
  logic             w_dec_valid;
  logic [DEPTH-1:0] w_match;
  logic             w_stall;
  sb_entry_t        w_new;

  assign w_dec_valid = (branch_value == r_epoch);

  hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rn     (dec_rn),
    .i_rm     (dec_rm),
    .i_rs     (dec_rs),
    .i_use_rn (use_rn),
    .i_use_rm (use_rm),
    .i_use_rs (use_rs),
    .i_new    (w_new),
    .o_match  (w_match)
  );

  // A flush overrides a stall: the decode instruction is discarded anyway.
  assign w_stall = w_dec_valid & (|w_match) & ~br_taken;

  always_comb begin
    w_new = '0;
    if (!w_stall && !br_taken) begin
      w_new.valid = w_dec_valid & dec_wr & (dec_rd != REG_PC);
      w_new.rd    = dec_rd;
      w_new.load  = dec_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epoch <= 1'b0;
      r_run   <= '0;
      r_total <= '0;
    end else begin
      if (br_taken) r_epoch <= ~r_epoch;
      if (w_stall) begin
        if (r_run != CNT_MAX)   r_run   <= r_run + CNT_W'(1);
        if (r_total != CNT_MAX) r_total <= r_total + CNT_W'(1);
      end else begin
        r_run <= '0;
      end
    end
  end

  assign sel_stall   = w_stall;
  assign branch_ref  = r_epoch;
  assign branch_in   = r_epoch;
  assign stall_run   = r_run;
  assign stall_total = r_total;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int DEPTH = 3;
  localparam int CNT_W = 16;
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_value = 1'b0;
  logic [3:0] dec_rn = '0, dec_rm = '0, dec_rs = '0, dec_rd = '0;
  logic use_rn = 1'b0, use_rm = 1'b0, use_rs = 1'b0;
  logic dec_wr = 1'b0, dec_load = 1'b0, br_taken = 1'b0;
  logic sel_stall, branch_ref, branch_in;
  logic [CNT_W-1:0] stall_run, stall_total;

  pipeline_hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .branch_value(branch_value),
    .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rs(dec_rs), .dec_rd(dec_rd),
    .use_rn(use_rn), .use_rm(use_rm), .use_rs(use_rs),
    .dec_wr(dec_wr), .dec_load(dec_load), .br_taken(br_taken),
    .sel_stall(sel_stall), .branch_ref(branch_ref), .branch_in(branch_in),
    .stall_run(stall_run), .stall_total(stall_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rn, rm, rs, rd;
    logic        urn, urm, urs, wr, ld, br, bv;
    logic        es;
    logic [15:0] erun;
    logic        eref;
  } vec_t;

  typedef struct {
    logic [3:0] rd;
    logic       ld;
    int         issue;
  } wr_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: list of accepted writers with the cycle they left decode.
  wr_t q[$];
  int  mc = 0;
  logic m_epoch = 1'b0;
  int  m_run = 0;
  int  m_total = 0;

  vec_t tv[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rn, input logic urn,
                              input logic [3:0] rm, input logic urm,
                              input logic [3:0] rd, input logic wr, input logic ld,
                              input logic br, input logic bv,
                              input logic es, input logic [15:0] erun, input logic eref);
    vec_t v;
    v.rn = rn; v.urn = urn; v.rm = rm; v.urm = urm; v.rs = 4'd0; v.urs = 1'b0;
    v.rd = rd; v.wr = wr; v.ld = ld; v.br = br; v.bv = bv;
    v.es = es; v.erun = erun; v.eref = eref;
    return v;
  endfunction

  function automatic logic m_hazard(input vec_t v);
    logic [3:0] s[3];
    logic       u[3];
    int         age;
    s[0] = v.rn; s[1] = v.rm; s[2] = v.rs;
    u[0] = v.urn; u[1] = v.urm; u[2] = v.urs;
    if (v.bv != m_epoch) return 1'b0;
    foreach (q[i]) begin
      age = mc - q[i].issue;
      if (age < 1 || age > DEPTH) continue;
      for (int j = 0; j < 3; j++)
        if (u[j] && s[j] != 4'd15 && s[j] == q[i].rd)
          if (!FWD || (age == 1 && q[i].ld)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_update(input vec_t v, input logic st);
    wr_t w;
    if (!st && !v.br && v.bv == m_epoch && v.wr && v.rd != 4'd15) begin
      w.rd = v.rd; w.ld = v.ld; w.issue = mc;
      q.push_back(w);
    end
    if (v.br) m_epoch = ~m_epoch;
    if (st) begin
      if (m_run < 65535) m_run++;
      if (m_total < 65535) m_total++;
    end else m_run = 0;
    mc++;
    while (q.size() > 0 && (mc - q[0].issue) > DEPTH) void'(q.pop_front());
  endtask

  task automatic drive(input vec_t v);
    dec_rn = v.rn; dec_rm = v.rm; dec_rs = v.rs; dec_rd = v.rd;
    use_rn = v.urn; use_rm = v.urm; use_rs = v.urs;
    dec_wr = v.wr; dec_load = v.ld; br_taken = v.br; branch_value = v.bv;
  endtask

  task automatic run_cycle(input vec_t v, input bit tbl);
    logic mst;
    @(negedge clk);
    drive(v);
    #4;
    mst = m_hazard(v) && !v.br;
    if (tbl) chk("tbl_stall", {31'b0, sel_stall}, {31'b0, v.es});
    else     chk("rnd_stall", {31'b0, sel_stall}, {31'b0, mst});
    @(posedge clk);
    m_update(v, mst);
    #1;
    if (tbl) begin
      chk("tbl_run", {16'b0, stall_run}, {16'b0, v.erun});
      chk("tbl_ref", {31'b0, branch_ref}, {31'b0, v.eref});
    end else begin
      chk("rnd_run",   {16'b0, stall_run},   m_run);
      chk("rnd_total", {16'b0, stall_total}, m_total);
      chk("rnd_ref",   {31'b0, branch_ref},  {31'b0, m_epoch});
      chk("rnd_in",    {31'b0, branch_in},   {31'b0, m_epoch});
      chk("max_stall_len", {31'b0, (stall_run <= 16'(DEPTH))}, 32'd1);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mc = 0; m_epoch = 1'b0; m_run = 0; m_total = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // rn urn rm urm rd wr ld br bv | stall run ref
    tv[0]  = mk(0,0, 0,0, 3,1,0, 0,0, 0, 0, 0);          // ADD R3
    tv[1]  = mk(3,1, 0,0, 0,0,0, 0,0, !FWD, FWD?0:1, 0); // reads R3
    tv[2]  = mk(3,1, 0,0, 0,0,0, 0,0, !FWD, FWD?0:2, 0);
    tv[3]  = mk(3,1, 0,0, 0,0,0, 0,0, !FWD, FWD?0:3, 0);
    tv[4]  = mk(3,1, 0,0, 0,0,0, 0,0, 0, 0, 0);
    tv[5]  = mk(0,0, 0,0, 4,1,1, 0,0, 0, 0, 0);          // LDR R4
    tv[6]  = mk(4,1, 0,0, 0,0,0, 0,0, 1, 1, 0);
    tv[7]  = mk(4,1, 0,0, 0,0,0, 0,0, !FWD, FWD?0:2, 0);
    tv[8]  = mk(4,1, 0,0, 0,0,0, 0,0, !FWD, FWD?0:3, 0);
    tv[9]  = mk(4,1, 0,0, 0,0,0, 0,0, 0, 0, 0);
    tv[10] = mk(0,0, 0,0, 15,1,1, 0,0, 0, 0, 0);         // writes PC
    tv[11] = mk(15,1, 0,0, 0,0,0, 0,0, 0, 0, 0);
    tv[12] = mk(0,0, 0,0, 5,1,1, 0,0, 0, 0, 0);
    tv[13] = mk(0,0, 15,1, 0,0,0, 0,0, 0, 0, 0);         // reads PC via Rm
    tv[14] = mk(0,0, 0,0, 0,0,0, 0,0, 0, 0, 0);
    tv[15] = mk(0,0, 0,0, 0,0,0, 0,0, 0, 0, 0);
    tv[16] = mk(0,0, 0,0, 6,1,0, 0,0, 0, 0, 0);
    tv[17] = mk(6,1, 0,0, 0,0,0, 1,0, 0, 0, 1);          // hazard + flush
    tv[18] = mk(6,1, 0,0, 7,1,0, 0,0, 0, 0, 1);          // stale epoch: NOP
    tv[19] = mk(7,1, 0,0, 0,0,0, 0,1, 0, 0, 1);          // R7 never entered
    tv[20] = mk(0,0, 0,0, 8,1,0, 0,1, 0, 0, 1);
    tv[21] = mk(8,1, 0,0, 0,0,0, 0,1, !FWD, FWD?0:1, 1);
    tv[22] = mk(0,0, 0,0, 0,0,0, 0,1, 0, 0, 1);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, sel_stall}, 32'd0);
    chk("rst_ref",   {31'b0, branch_ref}, 32'd0);
    chk("rst_in",    {31'b0, branch_in}, 32'd0);
    chk("rst_run",   {16'b0, stall_run}, 32'd0);
    chk("rst_total", {16'b0, stall_total}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    foreach (tv[i]) run_cycle(tv[i], 1'b1);
    chk("tbl_total", {16'b0, stall_total}, FWD ? 32'd1 : 32'd7);

    // Reset asserted mid-stall (epoch is 1 here)
    @(negedge clk);
    drive(mk(0,0, 0,0, 9,1,1, 0,1, 0, 0, 0));
    @(negedge clk);
    drive(mk(9,1, 0,0, 0,0,0, 0,1, 0, 0, 0));
    #2;
    chk("pre_rst_stall", {31'b0, sel_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'b0, sel_stall}, 32'd0);
    @(negedge clk);
    drive(mk(0,0, 0,0, 0,0,0, 0,0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_total", {16'b0, stall_total}, 32'd0);
    chk("post_rst_run",   {16'b0, stall_run}, 32'd0);
    chk("post_rst_ref",   {31'b0, branch_ref}, 32'd0);
    model_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      v.rn = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.rm = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.rs = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.rd = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      v.urn = 1'($urandom_range(0, 1));
      v.urm = 1'($urandom_range(0, 1));
      v.urs = ($urandom_range(0, 3) == 0);
      v.wr  = 1'($urandom_range(0, 1));
      v.ld  = ($urandom_range(0, 2) == 0);
      v.br  = ($urandom_range(0, 9) == 0);
      v.bv  = ($urandom_range(0, 4) == 0) ? ~m_epoch : m_epoch;
      v.es = 1'b0; v.erun = '0; v.eref = 1'b0;
      run_cycle(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
